// File: rtl/vga_fb_pkg.sv
// Shared types and default sizing for the VGA frame-buffer arbiter slice.
package vga_fb_pkg;

   localparam int unsigned DEF_ADDR_W        = 19;
   localparam int unsigned DEF_DATA_W        = 8;
   localparam int unsigned DEF_RD_LAT        = 2;
   localparam int unsigned DEF_HOST_MAX_WAIT = 16;

   typedef enum logic [1:0] {
      TAG_NONE,
      TAG_DISP,
      TAG_HOST
   } owner_tag_e;

   typedef enum logic [1:0] {
      S_DISP_PRI,
      S_HOST_PRI,
      S_HOST_FORCE
   } arb_state_e;

endpackage

// File: rtl/vga_fb_arbiter_if.sv
// Display, host and frame-buffer RAM signals of the arbiter.
// The slave modport is the arbiter's view; master is the surrounding system.
interface vga_fb_arbiter_if
   import vga_fb_pkg::*;
#(
   parameter int unsigned ADDR_W = DEF_ADDR_W,
   parameter int unsigned DATA_W = DEF_DATA_W
) ();

   logic              disp_req;
   logic [ADDR_W-1:0] disp_addr;
   logic              disp_gnt;
   logic              disp_rvalid;
   logic [DATA_W-1:0] disp_rdata;

   logic              host_req;
   logic              host_we;
   logic [ADDR_W-1:0] host_addr;
   logic [DATA_W-1:0] host_wdata;
   logic              host_gnt;
   logic              host_rvalid;
   logic [DATA_W-1:0] host_rdata;

   logic              mem_cs;
   logic              mem_we;
   logic [ADDR_W-1:0] mem_addr;
   logic [DATA_W-1:0] mem_wdata;
   logic [DATA_W-1:0] mem_rdata;

   modport slave (
      input  disp_req, disp_addr,
      output disp_gnt, disp_rvalid, disp_rdata,
      input  host_req, host_we, host_addr, host_wdata,
      output host_gnt, host_rvalid, host_rdata,
      output mem_cs, mem_we, mem_addr, mem_wdata,
      input  mem_rdata
   );

   modport master (
      output disp_req, disp_addr,
      input  disp_gnt, disp_rvalid, disp_rdata,
      output host_req, host_we, host_addr, host_wdata,
      input  host_gnt, host_rvalid, host_rdata,
      input  mem_cs, mem_we, mem_addr, mem_wdata,
      output mem_rdata
   );

endinterface

// File: rtl/vga_fb_arbiter_rd_return_pipe.sv
// Owner-tag shift register; tag_out lines up with the RAM read data of the
// access whose grant pushed tag_in RD_LAT+1 cycles earlier.
module fb_rd_return_pipe
   import vga_fb_pkg::*;
#(
   parameter int unsigned RD_LAT = DEF_RD_LAT
) (
   input  logic       CLK,
   input  logic       NRST,
   input  owner_tag_e tag_in,
   output owner_tag_e tag_out
);

   owner_tag_e stage_q [RD_LAT+1];
   owner_tag_e stage_d [RD_LAT+1];

   always_comb begin
      stage_d[0] = tag_in;
      for (int unsigned i = 1; i <= RD_LAT; i++) begin
         stage_d[i] = stage_q[i-1];
      end
   end

   always_ff @(posedge CLK or negedge NRST) begin
      if (!NRST) begin
         for (int unsigned i = 0; i <= RD_LAT; i++) begin
            stage_q[i] <= TAG_NONE;
         end
      end else begin
         for (int unsigned i = 0; i <= RD_LAT; i++) begin
            stage_q[i] <= stage_d[i];
         end
      end
   end

   assign tag_out = stage_q[RD_LAT];

endmodule

// File: rtl/vga_fb_arbiter.sv
// Single-port frame-buffer arbiter: display wins during active video, host
// wins during blanking, with a forced host slot after sustained refusal.
module vga_fb_arbiter
   import vga_fb_pkg::*;
#(
   parameter int unsigned ADDR_W        = DEF_ADDR_W,
   parameter int unsigned DATA_W        = DEF_DATA_W,
   parameter int unsigned RD_LAT        = DEF_RD_LAT,
   parameter int unsigned HOST_MAX_WAIT = DEF_HOST_MAX_WAIT
) (
   input  logic            CLK,
   input  logic            NRST,
   input  logic            RGB_EN,
   vga_fb_arbiter_if.slave bus
);

   localparam logic [7:0] STARVE_SAT   = 8'(HOST_MAX_WAIT);
   localparam logic [7:0] STARVE_FORCE = 8'(HOST_MAX_WAIT - 1);

   arb_state_e        state_q, state_d;
   logic [7:0]        starve_q, starve_d;
   logic              disp_gnt, host_gnt;

   logic              mem_cs_q, mem_cs_d;
   logic              mem_we_q, mem_we_d;
   logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
   logic [DATA_W-1:0] mem_wdata_q, mem_wdata_d;

   logic              disp_rvalid_q, disp_rvalid_d;
   logic [DATA_W-1:0] disp_rdata_q, disp_rdata_d;
   logic              host_rvalid_q, host_rvalid_d;
   logic [DATA_W-1:0] host_rdata_q, host_rdata_d;

   owner_tag_e        push_tag, ret_tag;

   // state_q is the single register stage on RGB_EN: DISP_PRI/HOST_PRI mirror
   // the registered flag, so next state is steered by the live RGB_EN.
   always_comb begin
      state_d  = state_q;
      starve_d = '0;
      disp_gnt = 1'b0;
      host_gnt = 1'b0;

      if (state_q == S_DISP_PRI) begin
         disp_gnt = bus.disp_req;
         host_gnt = bus.host_req & ~bus.disp_req;
      end else begin
         host_gnt = bus.host_req;
         disp_gnt = bus.disp_req & ~bus.host_req;
      end

      if ((state_q == S_DISP_PRI) && bus.host_req && !host_gnt) begin
         starve_d = (starve_q >= STARVE_SAT) ? starve_q : starve_q + 8'd1;
      end

      case (state_q)
         S_DISP_PRI: begin
            if (!RGB_EN) begin
               state_d = S_HOST_PRI;
            end else if (bus.host_req && !host_gnt && (starve_d == STARVE_FORCE)) begin
               state_d = S_HOST_FORCE;
            end
         end
         S_HOST_PRI: begin
            if (RGB_EN) begin
               state_d = S_DISP_PRI;
            end
         end
         S_HOST_FORCE: begin
            state_d = RGB_EN ? S_DISP_PRI : S_HOST_PRI;
         end
         default: begin
            state_d = S_DISP_PRI;
         end
      endcase
   end

   always_ff @(posedge CLK or negedge NRST) begin
      if (!NRST) begin
         state_q  <= S_DISP_PRI;
         starve_q <= '0;
      end else begin
         state_q  <= state_d;
         starve_q <= starve_d;
      end
   end

   always_comb begin
      mem_cs_d    = disp_gnt | host_gnt;
      mem_we_d    = mem_we_q;
      mem_addr_d  = mem_addr_q;
      mem_wdata_d = mem_wdata_q;
      push_tag    = TAG_NONE;

      if (host_gnt) begin
         mem_we_d    = bus.host_we;
         mem_addr_d  = bus.host_addr;
         mem_wdata_d = bus.host_wdata;
         push_tag    = bus.host_we ? TAG_NONE : TAG_HOST;
      end else if (disp_gnt) begin
         mem_we_d    = 1'b0;
         mem_addr_d  = bus.disp_addr;
         push_tag    = TAG_DISP;
      end
   end

   fb_rd_return_pipe #(
      .RD_LAT (RD_LAT)
   ) u_ret_pipe (
      .CLK     (CLK),
      .NRST    (NRST),
      .tag_in  (push_tag),
      .tag_out (ret_tag)
   );

   always_comb begin
      disp_rvalid_d = (ret_tag == TAG_DISP);
      host_rvalid_d = (ret_tag == TAG_HOST);
      disp_rdata_d  = disp_rvalid_d ? bus.mem_rdata : disp_rdata_q;
      host_rdata_d  = host_rvalid_d ? bus.mem_rdata : host_rdata_q;
   end

   always_ff @(posedge CLK or negedge NRST) begin
      if (!NRST) begin
         mem_cs_q      <= 1'b0;
         mem_we_q      <= 1'b0;
         mem_addr_q    <= '0;
         mem_wdata_q   <= '0;
         disp_rvalid_q <= 1'b0;
         disp_rdata_q  <= '0;
         host_rvalid_q <= 1'b0;
         host_rdata_q  <= '0;
      end else begin
         mem_cs_q      <= mem_cs_d;
         mem_we_q      <= mem_we_d;
         mem_addr_q    <= mem_addr_d;
         mem_wdata_q   <= mem_wdata_d;
         disp_rvalid_q <= disp_rvalid_d;
         disp_rdata_q  <= disp_rdata_d;
         host_rvalid_q <= host_rvalid_d;
         host_rdata_q  <= host_rdata_d;
      end
   end

   assign bus.disp_gnt    = disp_gnt;
   assign bus.host_gnt    = host_gnt;
   assign bus.mem_cs      = mem_cs_q;
   assign bus.mem_we      = mem_we_q;
   assign bus.mem_addr    = mem_addr_q;
   assign bus.mem_wdata   = mem_wdata_q;
   assign bus.disp_rvalid = disp_rvalid_q;
   assign bus.disp_rdata  = disp_rdata_q;
   assign bus.host_rvalid = host_rvalid_q;
   assign bus.host_rdata  = host_rdata_q;

endmodule

// File: tb/tb_vga_fb_arbiter.sv
// Bench for vga_fb_arbiter: RAM model, transaction-level reference model
// checked every cycle, directed scenarios and a randomized phase.
module tb_vga_fb_arbiter;
   import vga_fb_pkg::*;

   localparam int unsigned ADDR_W = 19;
   localparam int unsigned DATA_W = 8;
   localparam int unsigned RD_LAT = 2;
   localparam int unsigned MAXW   = 16;

   logic CLK    = 1'b0;
   logic NRST   = 1'b0;
   logic RGB_EN = 1'b1;

   always #5 CLK = ~CLK;

   vga_fb_arbiter_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

   vga_fb_arbiter #(
      .ADDR_W        (ADDR_W),
      .DATA_W        (DATA_W),
      .RD_LAT        (RD_LAT),
      .HOST_MAX_WAIT (MAXW)
   ) dut (
      .CLK    (CLK),
      .NRST   (NRST),
      .RGB_EN (RGB_EN),
      .bus    (bus)
   );

   int n_cmp = 0;
   int n_bad = 0;

   function automatic logic [7:0] init_val(input logic [18:0] a);
      return a[7:0] ^ a[15:8] ^ 8'h3C;
   endfunction

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h at t=%0t", name, act, exp, $time);
      end
   endtask

   // Frame-buffer RAM with RD_LAT cycles from strobe to data
   logic [7:0] ram [logic [18:0]];
   logic [7:0] rd_pipe [RD_LAT];

   function automatic logic [7:0] ram_rd(input logic [18:0] a);
      return ram.exists(a) ? ram[a] : init_val(a);
   endfunction

   always @(posedge CLK) begin
      if (bus.mem_cs && bus.mem_we) ram[bus.mem_addr] = bus.mem_wdata;
      rd_pipe[0] <= (bus.mem_cs && !bus.mem_we) ? ram_rd(bus.mem_addr) : 8'hEE;
      for (int i = 1; i < RD_LAT; i++) rd_pipe[i] <= rd_pipe[i-1];
   end
   assign bus.mem_rdata = rd_pipe[RD_LAT-1];

   // Reference model: per-cycle grant rule, expected command, return queue
   typedef struct {
      int unsigned due;
      logic        host;
      logic [7:0]  data;
   } ret_t;

   ret_t        rq [$];
   logic [7:0]  shadow [logic [18:0]];
   logic        m_rgb = 1'b1, m_force = 1'b0;
   int unsigned m_ref = 0, mcyc = 0;
   logic        e_cs = 0, e_we = 0, e_dv = 0, e_hv = 0;
   logic [18:0] e_addr = '0;
   logic [7:0]  e_wd = '0, e_dd = '0, e_hd = '0;

   function automatic logic [7:0] sh_rd(input logic [18:0] a);
      return shadow.exists(a) ? shadow[a] : init_val(a);
   endfunction

   always @(negedge CLK) begin : model
      logic hp, gd, gh;
      ret_t r;
      if (!NRST) begin
         rq.delete();
         m_rgb = 1'b1; m_force = 1'b0; m_ref = 0;
         e_cs = 0; e_we = 0; e_addr = '0; e_wd = '0;
         e_dv = 0; e_hv = 0; e_dd = '0; e_hd = '0;
      end else begin
         mcyc++;
         hp = !m_rgb || m_force;
         gd = hp ? (bus.disp_req && !bus.host_req) : bus.disp_req;
         gh = hp ? bus.host_req : (bus.host_req && !bus.disp_req);
         chk("disp_gnt", bus.disp_gnt, gd);
         chk("host_gnt", bus.host_gnt, gh);
         chk("mem_cs", bus.mem_cs, e_cs);
         chk("mem_we", bus.mem_we, e_we);
         chk("mem_addr", bus.mem_addr, e_addr);
         chk("mem_wdata", bus.mem_wdata, e_wd);
         chk("disp_rvalid", bus.disp_rvalid, e_dv);
         chk("host_rvalid", bus.host_rvalid, e_hv);
         chk("disp_rdata", bus.disp_rdata, e_dd);
         chk("host_rdata", bus.host_rdata, e_hd);

         e_cs = gd || gh;
         if (gh) begin
            e_we = bus.host_we; e_addr = bus.host_addr; e_wd = bus.host_wdata;
            if (bus.host_we) shadow[bus.host_addr] = bus.host_wdata;
            else begin
               r.due = mcyc + 2 + RD_LAT; r.host = 1'b1; r.data = sh_rd(bus.host_addr);
               rq.push_back(r);
            end
         end else if (gd) begin
            e_we = 1'b0; e_addr = bus.disp_addr;
            r.due = mcyc + 2 + RD_LAT; r.host = 1'b0; r.data = sh_rd(bus.disp_addr);
            rq.push_back(r);
         end
         e_dv = 0; e_hv = 0;
         if (rq.size() > 0 && rq[0].due == mcyc + 1) begin
            r = rq.pop_front();
            if (r.host) begin e_hv = 1; e_hd = r.data; end
            else begin e_dv = 1; e_dd = r.data; end
         end

         if (!hp && bus.host_req && !gh) m_ref++;
         else m_ref = 0;
         m_force = !hp && bus.host_req && !gh && (m_ref == MAXW - 1);
         m_rgb = RGB_EN;
      end
   end

   task automatic step();
      @(posedge CLK);
      #1;
   endtask

   initial begin : watchdog
      #1ms;
      n_bad++;
      $display("FAIL watchdog: simulation time limit reached");
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $fatal(1, "timeout");
   end

   initial begin : stim
      int ngnt, rv_at, hv_at, dv_at, refused, hcnt, dcnt, wcnt;
      logic [7:0] rv_data, hv_data, dv_data;
      logic got, gd, gh;

      bus.disp_req = 0; bus.disp_addr = '0;
      bus.host_req = 0; bus.host_we = 0; bus.host_addr = '0; bus.host_wdata = '0;

      step();
      chk("rst_mem_cs", bus.mem_cs, 0);
      chk("rst_disp_rvalid", bus.disp_rvalid, 0);
      chk("rst_host_rvalid", bus.host_rvalid, 0);
      chk("rst_mem_addr", bus.mem_addr, 0);
      step(); step();
      NRST = 1;
      step(); step();

      // Display streaming from address 0
      ngnt = 0; rv_at = -1; rv_data = '0;
      bus.disp_req = 1; bus.disp_addr = '0;
      for (int i = 0; i < 10; i++) begin
         @(negedge CLK);
         if (bus.disp_gnt) ngnt++;
         if (bus.disp_rvalid && rv_at < 0) begin rv_at = i; rv_data = bus.disp_rdata; end
         if (i == 1) chk("d1_mem_addr_c1", bus.mem_addr, 0);
         if (i == 3) chk("d1_mem_addr_c3", bus.mem_addr, 2);
         step();
         bus.disp_addr = bus.disp_addr + 19'd1;
      end
      bus.disp_req = 0;
      chk("d1_grants", ngnt, 10);
      chk("d1_first_rvalid_cycle", rv_at, 4);
      chk("d1_first_rdata", rv_data, 8'h3C);
      step();

      // Host starved by a continuous display stream
      refused = 0; got = 0;
      bus.disp_req = 1; bus.disp_addr = 19'h40;
      bus.host_req = 1; bus.host_we = 1; bus.host_addr = 19'h100; bus.host_wdata = 8'hA5;
      for (int i = 0; i < 40 && !got; i++) begin
         @(negedge CLK);
         if (bus.host_gnt) begin
            got = 1;
            chk("d2_disp_gnt_forced", bus.disp_gnt, 0);
         end else refused++;
         step();
         if (got) bus.host_req = 0;
         else bus.disp_addr = bus.disp_addr + 19'd1;
      end
      chk("d2_host_granted", got, 1);
      chk("d2_refusals", refused, 15);
      bus.disp_req = 0;
      step(); step(); step();
      chk("d2_ram_100", ram_rd(19'h100), 8'hA5);

      // Blanking: host owns the memory while it requests
      RGB_EN = 0;
      step();
      hcnt = 0; dcnt = 0;
      bus.disp_req = 1; bus.disp_addr = 19'h30;
      bus.host_req = 1; bus.host_we = 1; bus.host_addr = 19'h200; bus.host_wdata = 8'h01;
      for (int i = 0; i < 6; i++) begin
         @(negedge CLK);
         if (bus.host_gnt) hcnt++;
         if (bus.disp_gnt) dcnt++;
         step();
         bus.host_addr = bus.host_addr + 19'd1;
         bus.host_wdata = bus.host_wdata + 8'd1;
      end
      chk("d3_host_grants", hcnt, 6);
      chk("d3_disp_grants", dcnt, 0);
      bus.host_req = 0;
      @(negedge CLK);
      chk("d3_disp_after_drop", bus.disp_gnt, 1);
      step();
      bus.disp_req = 0;
      step();

      // Host then display read across an RGB_EN 1->0 edge
      RGB_EN = 1;
      step(); step();
      bus.host_req = 1; bus.host_we = 0; bus.host_addr = 19'd5;
      RGB_EN = 0;
      @(negedge CLK);
      chk("d4_host_gnt", bus.host_gnt, 1);
      step();
      bus.host_req = 0;
      bus.disp_req = 1; bus.disp_addr = 19'd6;
      @(negedge CLK);
      chk("d4_disp_gnt", bus.disp_gnt, 1);
      step();
      bus.disp_req = 0;
      hv_at = -1; dv_at = -1; hv_data = '0; dv_data = '0;
      for (int i = 0; i < 8; i++) begin
         @(negedge CLK);
         if (bus.host_rvalid && hv_at < 0) begin hv_at = i; hv_data = bus.host_rdata; end
         if (bus.disp_rvalid && dv_at < 0) begin dv_at = i; dv_data = bus.disp_rdata; end
         step();
      end
      chk("d4_host_rvalid_cycle", hv_at, 2);
      chk("d4_disp_rvalid_cycle", dv_at, 3);
      chk("d4_host_rdata", hv_data, 8'h39);
      chk("d4_disp_rdata", dv_data, 8'h3A);

      // Reset two cycles after a read grant
      bus.host_req = 1; bus.host_we = 0; bus.host_addr = 19'd7;
      @(negedge CLK);
      chk("d5_host_gnt", bus.host_gnt, 1);
      step();
      bus.host_req = 0;
      step();
      NRST = 0;
      #1;
      chk("d5_rst_mem_cs", bus.mem_cs, 0);
      chk("d5_rst_mem_we", bus.mem_we, 0);
      chk("d5_rst_mem_addr", bus.mem_addr, 0);
      chk("d5_rst_mem_wdata", bus.mem_wdata, 0);
      chk("d5_rst_host_rvalid", bus.host_rvalid, 0);
      chk("d5_rst_host_rdata", bus.host_rdata, 0);
      chk("d5_rst_disp_rvalid", bus.disp_rvalid, 0);
      chk("d5_rst_disp_rdata", bus.disp_rdata, 0);
      step(); step();
      NRST = 1;
      hcnt = 0;
      for (int i = 0; i < 8; i++) begin
         @(negedge CLK);
         if (bus.host_rvalid || bus.disp_rvalid) hcnt++;
         step();
      end
      chk("d5_no_rvalid_after_reset", hcnt, 0);
      got = 0;
      bus.host_req = 1; bus.host_we = 0; bus.host_addr = 19'd7;
      for (int i = 0; i < 10 && !got; i++) begin
         @(negedge CLK);
         got = bus.host_gnt;
         step();
      end
      bus.host_req = 0;
      chk("d5_resume_gnt", got, 1);
      got = 0;
      for (int i = 0; i < 12 && !got; i++) begin
         @(negedge CLK);
         if (bus.host_rvalid) begin
            got = 1;
            chk("d5_resume_rdata", bus.host_rdata, 8'h3B);
         end
         step();
      end
      chk("d5_resume_rvalid", got, 1);

      // Host write: single write strobe, no read return
      got = 0;
      bus.host_req = 1; bus.host_we = 1; bus.host_addr = 19'h300; bus.host_wdata = 8'h5A;
      for (int i = 0; i < 10 && !got; i++) begin
         @(negedge CLK);
         got = bus.host_gnt;
         step();
      end
      bus.host_req = 0;
      chk("d6_write_gnt", got, 1);
      wcnt = 0; hcnt = 0;
      for (int i = 0; i < 6; i++) begin
         @(negedge CLK);
         if (bus.mem_cs && bus.mem_we) wcnt++;
         if (bus.host_rvalid) hcnt++;
         step();
      end
      chk("d6_write_strobes", wcnt, 1);
      chk("d6_host_rvalid", hcnt, 0);
      chk("d6_ram_300", ram_rd(19'h300), 8'h5A);

      // Randomized traffic: mixed phase, then display-heavy phase
      for (int ph = 0; ph < 2; ph++) begin
         int dp, tog;
         dp  = (ph == 0) ? 60 : 100;
         tog = (ph == 0) ? 40 : 200;
         for (int i = 0; i < 1500; i++) begin
            @(negedge CLK);
            gd = bus.disp_gnt; gh = bus.host_gnt;
            step();
            if (!bus.disp_req || gd) begin
               bus.disp_req  = ($urandom_range(99) < dp);
               bus.disp_addr = 19'($urandom_range(63));
            end
            if (!bus.host_req || gh) begin
               bus.host_req   = ($urandom_range(99) < 40);
               bus.host_we    = 1'($urandom_range(1));
               bus.host_addr  = 19'($urandom_range(63));
               bus.host_wdata = 8'($urandom);
            end
            if ($urandom_range(tog - 1) == 0) RGB_EN = ~RGB_EN;
         end
      end

      // Let outstanding traffic drain
      for (int i = 0; i < 40; i++) begin
         @(negedge CLK);
         gd = bus.disp_gnt; gh = bus.host_gnt;
         step();
         if (gd) bus.disp_req = 0;
         if (gh) bus.host_req = 0;
      end
      chk("end_idle_disp", bus.disp_req, 0);
      chk("end_idle_host", bus.host_req, 0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule

// File: doc/vga_fb_arbiter.md
Name: vga_fb_arbiter

Overview:
- Shares one single-port frame-buffer memory between two requesters: the display fetch path, which supplies pixels to the VGA sync controller during active video, and a host writer/reader, which updates the image.
- Uses the sync controller's RGB_EN to choose priority: display during active video, host during blanking.
- Includes an anti-starvation counter for the host, and routes read returns back to the requester that issued them.
- Sits between the sync/pixel pipeline, the host bus, and the frame-buffer RAM.

Parameters:
- ADDR_W, 19, frame-buffer word address width (640x480 = 307200 words).
- DATA_W, 8, pixel/data word width.
- RD_LAT, 2, memory read latency in cycles from mem_cs (registered) to mem_rdata valid; legal range 1..4.
- HOST_MAX_WAIT, 16, cycles a requesting host may be refused during active video before it is granted one forced slot; legal range 2..255.

Ports:
- CLK  in  1  system clock; all logic rising-edge.
- NRST  in  1  asynchronous active-low reset.
- RGB_EN  in  1  active-video flag from the sync controller; 1 = display priority.
- disp_req  in  1  display fetch request.
- disp_addr  in  ADDR_W  display read address.
- disp_gnt  out  1  display request accepted this cycle (combinational).
- disp_rvalid  out  1  display read data valid.
- disp_rdata  out  DATA_W  display read data.
- host_req  in  1  host request.
- host_we  in  1  1 = write, 0 = read.
- host_addr  in  ADDR_W  host address.
- host_wdata  in  DATA_W  host write data.
- host_gnt  out  1  host request accepted this cycle (combinational).
- host_rvalid  out  1  host read data valid.
- host_rdata  out  DATA_W  host read data.
- mem_cs  out  1  memory access strobe (registered).
- mem_we  out  1  memory write enable (registered).
- mem_addr  out  ADDR_W  memory address (registered).
- mem_wdata  out  DATA_W  memory write data (registered).
- mem_rdata  in  DATA_W  memory read data, valid RD_LAT cycles after mem_cs.

Behaviour:
- Reset (NRST low, asynchronous):
  - All registered outputs go to 0: mem_*, disp_rvalid/rdata, host_rvalid/rdata.
  - State returns to S_DISP_PRI, starve_cnt to 0, and the return-tag pipeline is flushed.
  - Reads in flight when reset asserts are discarded; no rvalid follows reset release.
- RGB_EN is registered once (rgb_en_q); mode changes take effect the cycle after RGB_EN changes.
- States:
  - S_DISP_PRI: rgb_en_q = 1.
  - S_HOST_PRI: rgb_en_q = 0.
  - S_HOST_FORCE: one-cycle state.
- Transitions:
  - S_DISP_PRI -> S_HOST_PRI when rgb_en_q = 0.
  - S_HOST_PRI -> S_DISP_PRI when rgb_en_q = 1.
  - S_DISP_PRI -> S_HOST_FORCE when host_req = 1 and starve_cnt = HOST_MAX_WAIT-1 and the host is refused this cycle.
  - S_HOST_FORCE -> S_DISP_PRI or S_HOST_PRI per rgb_en_q after exactly one cycle.
- Grant per cycle, at most one grant:
  - S_DISP_PRI: disp_gnt = disp_req; host_gnt = host_req & ~disp_req.
  - S_HOST_PRI: host_gnt = host_req; disp_gnt = disp_req & ~host_req.
  - S_HOST_FORCE: host_gnt = host_req; disp_gnt = disp_req & ~host_req.
- A requester holds req/addr/data stable until its grant is seen. A grant in cycle N consumes that cycle's request.
- starve_cnt:
  - Increments each cycle host_req = 1 and host_gnt = 0, saturating at HOST_MAX_WAIT.
  - Clears on host_gnt or host_req = 0.
  - Counts only in S_DISP_PRI.
- Memory command: a grant in cycle N drives mem_cs/we/addr/wdata in cycle N+1. The display path is always a read (mem_we = 0). With no grant, mem_cs = 0 and the other mem_* hold their previous values.
- Read return:
  - Each read pushes a tag (DISP or HOST) into a pipeline RD_LAT+1 deep.
  - mem_rdata is registered to the owner's rdata in cycle N+2+RD_LAT; the owner's rvalid pulses for exactly one cycle then.
  - Writes push a NONE tag and produce no rvalid.
- Returns are strictly in order. Back-to-back grants give one access per cycle (throughput 1).
- Mode switches never drop or reorder in-flight returns.

Decomposition:
- Package vga_fb_pkg:
  - owner tag enum {TAG_NONE, TAG_DISP, TAG_HOST};
  - state enum {S_DISP_PRI, S_HOST_PRI, S_HOST_FORCE};
  - default ADDR_W, DATA_W, RD_LAT, HOST_MAX_WAIT constants.
- Sub-module fb_rd_return_pipe:
  - parameterised tag shift register, depth RD_LAT+1;
  - outputs the owner tag aligned with mem_rdata.

Test Plan:
- Reset, then RGB_EN = 1 and disp_req held high with disp_addr incrementing from 0 -> disp_gnt every cycle; mem_addr 0,1,2... from cycle 1; disp_rvalid from cycle 4 (RD_LAT = 2) with data matching the memory model.
- RGB_EN = 1, disp_req and host_req (write, addr 0x100, data 0xA5) held high -> host refused 15 cycles, granted on the 16th; memory word 0x100 = 0xA5; disp_gnt low only in that cycle.
- RGB_EN = 0, both requesting -> host_gnt every cycle, disp_gnt 0; host_req dropped -> disp_gnt the same cycle.
- Interleaved host read (addr 5) and display read (addr 6) in consecutive cycles across an RGB_EN 1->0 edge -> host_rvalid then disp_rvalid on consecutive cycles, correct data, no loss.
- NRST pulsed low two cycles after a read grant -> no rvalid afterwards; mem_cs = 0 and all outputs 0 immediately; normal operation resumes after release.
- Host write grant -> mem_we = 1 for one cycle; host_rvalid never asserts.
